rf80386_prefetch_queue: RTL and testbench

Parametrised instruction-byte prefetch queue between the instruction cache and the rf80386 decoder. It requests aligned code bundles, accepts them on cache hit, and discards leading bytes when a redirect target is misaligned. It then presents a window of the oldest bytes and retires a variable number of bytes per cycle. This replaces the fixed single-bundle, one-byte-per-cycle shift buffer with configurable depth, a multi-byte consume, and flush/redirect handling.

---
 rtl/rf80386_prefetch_queue.sv | 130 +++++++++++++
 tb/tb_rf80386_prefetch_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rf80386_prefetch_queue.sv
// Instruction-byte prefetch queue: fetches aligned code bundles from the I-cache and
// presents the oldest queued bytes to the decoder, retiring a variable count per cycle.
module rf80386_prefetch_queue #(
  parameter int unsigned BUNDLE_BYTES = 16,
  parameter int unsigned DEPTH_BYTES  = 64,
  parameter int unsigned PEEK_BYTES   = 8,
  parameter logic [31:0] RESET_IP     = 32'hFFFF_FFF0
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic [31:0]                     flush_ip_i,
  output logic                            fetch_req_o,
  output logic [31:0]                     fetch_adr_o,
  input  logic [8*BUNDLE_BYTES-1:0]       bundle_i,
  input  logic                            ihit_i,
  output logic [8*PEEK_BYTES-1:0]         peek_o,
  output logic [$clog2(DEPTH_BYTES):0]    count_o,
  output logic [31:0]                     ip_o,
  input  logic [$clog2(PEEK_BYTES):0]     consume_i,
  output logic                            underrun_o,
  output logic [31:0]                     miss_count_o
);

  localparam int unsigned BW = $clog2(BUNDLE_BYTES);
  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, count_c, count_d;
  logic [BW-1:0] skip_q, skip_d;
  logic [31:0]   adr_q, adr_d, ip_q, ip_d, miss_q, miss_d;
  logic          accept_c, consume_ok_c;
  logic [7:0]    mem_q [DEPTH_BYTES];

  // Next-state and datapath update; flush overrides any bundle or consume in the cycle.
  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    skip_d       = skip_q;
    adr_d        = adr_q;
    ip_d         = ip_q;
    miss_d       = miss_q;
    count_c      = wr_q - rd_q;
    accept_c     = (state_q == S_FILL) & ihit_i & ~flush_i;
    consume_ok_c = PW'(consume_i) <= count_c;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      ip_d    = flush_ip_i;
      adr_d   = {flush_ip_i[31:BW], BW'(0)};
      skip_d  = flush_ip_i[BW-1:0];
      state_d = S_FILL;
    end else begin
      if (accept_c) begin
        wr_d   = wr_q + PW'(BUNDLE_BYTES) - PW'(skip_q);
        adr_d  = adr_q + 32'(BUNDLE_BYTES);
        skip_d = '0;
      end
      if (consume_ok_c) begin
        rd_d = rd_q + PW'(consume_i);
        ip_d = ip_q + 32'(consume_i);
      end
      if ((state_q == S_FILL) && !ihit_i) begin
        miss_d = miss_q + 32'd1;
      end
    end
    count_d = wr_d - rd_d;
    if (!flush_i) begin
      case (state_q)
        S_IDLE:  state_d = S_FILL;
        S_FILL:  if (count_d > PW'(DEPTH_BYTES - BUNDLE_BYTES)) state_d = S_FULL;
        S_FULL:  if (count_d <= PW'(DEPTH_BYTES - BUNDLE_BYTES)) state_d = S_FILL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      skip_q  <= RESET_IP[BW-1:0];
      adr_q   <= {RESET_IP[31:BW], BW'(0)};
      ip_q    <= RESET_IP;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      skip_q  <= skip_d;
      adr_q   <= adr_d;
      ip_q    <= ip_d;
      miss_q  <= miss_d;
    end
  end

  // Byte storage; leading bytes below skip belong to a misaligned redirect and are dropped.
  always_ff @(posedge clk_i) begin
    if (accept_c) begin
      for (int unsigned j = 0; j < BUNDLE_BYTES; j++) begin
        if (j >= 32'(skip_q)) begin
          mem_q[AW'(wr_q + PW'(j) - PW'(skip_q))] <= bundle_i[8*j +: 8];
        end
      end
    end
  end

  // Decoder window; bytes beyond the valid count read as NOP.
  always_comb begin
    peek_o = '0;
    for (int unsigned k = 0; k < PEEK_BYTES; k++) begin
      peek_o[8*k +: 8] = (PW'(k) < count_c) ? mem_q[AW'(rd_q + PW'(k))] : 8'h90;
    end
  end

  assign fetch_req_o  = (state_q == S_FILL);
  assign fetch_adr_o  = adr_q;
  assign ip_o         = ip_q;
  assign count_o      = count_c;
  assign miss_count_o = miss_q;
  assign underrun_o   = ~consume_ok_c;

endmodule

// File: tb/tb_rf80386_prefetch_queue.sv
// Bench for rf80386_prefetch_queue: directed vector table plus a byte-queue scoreboard
// that tracks every fetched byte by linear address.
module tb_rf80386_prefetch_queue;

  logic         clk = 1'b0;
  logic         rst_ni, flush_i, ihit_i, fetch_req_o, underrun_o;
  logic [31:0]  flush_ip_i, fetch_adr_o, ip_o, miss_count_o;
  logic [127:0] bundle_i;
  logic [63:0]  peek_o;
  logic [6:0]   count_o;
  logic [3:0]   consume_i;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  rf80386_prefetch_queue dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .flush_ip_i(flush_ip_i),
    .fetch_req_o(fetch_req_o), .fetch_adr_o(fetch_adr_o), .bundle_i(bundle_i),
    .ihit_i(ihit_i), .peek_o(peek_o), .count_o(count_o), .ip_o(ip_o),
    .consume_i(consume_i), .underrun_o(underrun_o), .miss_count_o(miss_count_o)
  );

  // Scoreboard state
  logic [7:0]  m_q[$];
  logic [31:0] m_ip, m_adr, m_miss;
  logic [3:0]  m_skip;
  logic        m_req, m_idle;

  typedef struct {
    int fl, fip, hit, cons, und, cnt, req, ip, adr, miss;
  } vec_t;
  vec_t tbl[25];

  // Code memory contents as a function of linear address
  function automatic logic [7:0] fbyte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [127:0] mk_bundle(input logic [31:0] adr);
    logic [127:0] b;
    for (int j = 0; j < 16; j++) b[8*j +: 8] = fbyte(adr + 32'(j));
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ip   = 32'hFFFF_FFF0;
    m_adr  = 32'hFFFF_FFF0;
    m_skip = 4'h0;
    m_miss = 32'h0;
    m_req  = 1'b0;
    m_idle = 1'b1;
  endtask

  task automatic check_model(input logic [3:0] cons);
    logic [63:0] e;
    for (int k = 0; k < 8; k++) e[8*k +: 8] = (k < m_q.size()) ? m_q[k] : 8'h90;
    chk("req", 32'(fetch_req_o), 32'(m_req));
    chk("adr", fetch_adr_o, m_adr);
    chk("count", 32'(count_o), 32'(m_q.size()));
    chk("ip", ip_o, m_ip);
    chk("miss", miss_count_o, m_miss);
    chk("underrun", 32'(underrun_o), 32'(32'(cons) > 32'(m_q.size())));
    chk("peek_lo", peek_o[31:0], e[31:0]);
    chk("peek_hi", peek_o[63:32], e[63:32]);
  endtask

  task automatic model_step(input logic fl, input logic [31:0] fip, input logic hit,
                            input logic [3:0] cons);
    int old;
    old = m_q.size();
    if (!rst_ni) begin
      model_reset();
      return;
    end
    if (fl) begin
      m_q.delete();
      m_ip   = fip;
      m_adr  = {fip[31:4], 4'h0};
      m_skip = fip[3:0];
      m_req  = 1'b1;
      m_idle = 1'b0;
      return;
    end
    if (m_req && !hit) m_miss = m_miss + 32'd1;
    if (int'(cons) <= old) begin
      for (int i = 0; i < int'(cons); i++) void'(m_q.pop_front());
      m_ip = m_ip + 32'(cons);
    end
    if (m_req && hit) begin
      for (int j = int'(m_skip); j < 16; j++) m_q.push_back(fbyte(m_adr + 32'(j)));
      m_adr  = m_adr + 32'd16;
      m_skip = 4'h0;
    end
    if (m_idle) begin
      m_idle = 1'b0;
      m_req  = 1'b1;
    end else if (m_req && m_q.size() > 48) begin
      m_req = 1'b0;
    end else if (!m_req && m_q.size() <= 48) begin
      m_req = 1'b1;
    end
  endtask

  // One clock: drive, compare against scoreboard, advance model and DUT together
  task automatic run_cycle(input logic fl, input logic [31:0] fip, input logic hit,
                           input logic [3:0] cons, input int und);
    flush_i    = fl;
    flush_ip_i = fip;
    ihit_i     = hit;
    consume_i  = cons;
    bundle_i   = mk_bundle(fetch_adr_o);
    #1;
    if (und >= 0) chk("vec_underrun", 32'(underrun_o), 32'(und));
    check_model(cons);
    model_step(fl, fip, hit, cons);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; flush_ip_i = 32'h0; ihit_i = 1'b0;
    consume_i = 4'h0; bundle_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(fetch_req_o), 32'h0);
    chk("rst_adr", fetch_adr_o, 32'hFFFF_FFF0);
    chk("rst_ip", ip_o, 32'hFFFF_FFF0);
    chk("rst_count", 32'(count_o), 32'h0);
    chk("rst_peek", peek_o[31:0], 32'h9090_9090);
    rst_ni = 1'b1;

    tbl[0]  = '{0, 0, 1, 0, 0, 0, 1, 'hFFFF_FFF0, 'hFFFF_FFF0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 16, 1, 'hFFFF_FFF0, 'h0, 0};
    tbl[2]  = '{1, 'h1005, 1, 0, 0, 0, 1, 'h1005, 'h1000, 0};
    tbl[3]  = '{0, 0, 1, 0, 0, 11, 1, 'h1005, 'h1010, 0};
    tbl[4]  = '{0, 0, 0, 5, 0, 6, 1, 'h100A, 'h1010, 1};
    for (int i = 5; i <= 10; i++) tbl[i] = '{0, 0, 0, 0, 0, 6, 1, 'h100A, 'h1010, i - 3};
    tbl[11] = '{1, 'h2000, 0, 0, 0, 0, 1, 'h2000, 'h2000, 7};
    for (int i = 12; i <= 15; i++)
      tbl[i] = '{0, 0, 1, 0, 0, 16 * (i - 11), (i < 15) ? 1 : 0, 'h2000, 'h2000 + 16 * (i - 11), 7};
    tbl[16] = '{0, 0, 1, 8, 0, 56, 0, 'h2008, 'h2040, 7};
    tbl[17] = '{0, 0, 1, 8, 0, 48, 1, 'h2010, 'h2040, 7};
    for (int i = 18; i <= 22; i++)
      tbl[i] = '{0, 0, 0, 8, 0, 40 - 8 * (i - 18), 1, 'h2018 + 8 * (i - 18), 'h2040, 8 + (i - 18)};
    tbl[23] = '{0, 0, 0, 5, 0, 3, 1, 'h203D, 'h2040, 13};
    tbl[24] = '{0, 0, 1, 5, 1, 19, 1, 'h203D, 'h2050, 13};

    for (int i = 0; i < 25; i++) begin
      run_cycle(1'(tbl[i].fl), 32'(tbl[i].fip), 1'(tbl[i].hit), 4'(tbl[i].cons), tbl[i].und);
      chk($sformatf("r%0d_count", i), 32'(count_o), 32'(tbl[i].cnt));
      chk($sformatf("r%0d_req", i), 32'(fetch_req_o), 32'(tbl[i].req));
      chk($sformatf("r%0d_ip", i), ip_o, 32'(tbl[i].ip));
      chk($sformatf("r%0d_adr", i), fetch_adr_o, 32'(tbl[i].adr));
      chk($sformatf("r%0d_miss", i), miss_count_o, 32'(tbl[i].miss));
    end
    chk("first_byte_after_flush", 32'(peek_o[7:0]), 32'(fbyte(32'h203D)));

    // Random traffic: pointer wrap, FULL/FILL churn, occasional redirects and underruns
    for (int i = 0; i < 400; i++)
      run_cycle($urandom_range(0, 31) == 0, $urandom, $urandom_range(0, 3) != 0,
                4'($urandom_range(0, 8)), -1);

    // Reset in the middle of a fill with 40 bytes queued and a hit in flight
    run_cycle(1'b1, 32'h3008, 1'b0, 4'h0, -1);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 32'h0, 1'b1, 4'h0, -1);
    chk("midfill_count", 32'(count_o), 32'd40);
    rst_ni = 1'b0;
    run_cycle(1'b0, 32'h0, 1'b1, 4'h0, -1);
    consume_i = 4'h0;
    #1;
    chk("rst2_req", 32'(fetch_req_o), 32'h0);
    chk("rst2_adr", fetch_adr_o, 32'hFFFF_FFF0);
    chk("rst2_ip", ip_o, 32'hFFFF_FFF0);
    chk("rst2_count", 32'(count_o), 32'h0);
    chk("rst2_peek_lo", peek_o[31:0], 32'h9090_9090);
    chk("rst2_peek_hi", peek_o[63:32], 32'h9090_9090);
    chk("rst2_miss", miss_count_o, 32'h0);
    chk("rst2_underrun", 32'(underrun_o), 32'h0);
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 1'b1, 4'(i), -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
